// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the writeback stage.
// Holds wb_sel / ld_size / state enums and the return-address register index.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_WORD = 2'b00,
        LD_HALF = 2'b01,
        LD_BYTE = 2'b10
    } ld_size_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_WAIT_MEM = 2'b01,
        S_WRITE    = 2'b10
    } wb_state_e;

    localparam int RA_REG = 31;

endpackage

// File: rtl/wb_stage_load_extend.sv
// load_extend: little-endian byte/half/word extraction with sign/zero extend.
// Ports: mem_rdata, addr[1:0], size, sgn in; result (WIDTH) out.
module load_extend
    import wb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic [1:0]       addr,
    input  logic [1:0]       size,
    input  logic             sgn,
    output logic [WIDTH-1:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = mem_rdata[7:0];
        unique case (addr)
            2'd1:    b = mem_rdata[15:8];
            2'd2:    b = mem_rdata[23:16];
            2'd3:    b = mem_rdata[31:24];
            default: b = mem_rdata[7:0];
        endcase
    end

    assign h = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        result = mem_rdata;
        if (size == LD_BYTE)
            result = {{(WIDTH-8){sgn & b[7]}}, b};
        else if (size == LD_HALF)
            result = {{(WIDTH-16){sgn & h[15]}}, h};
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback FSM driving the register file write port as a
// one-cycle registered strobe. Inputs: ex_* retiring instruction with
// valid/ready, mem_rvalid/mem_rdata load return. Outputs: regWriteEn,
// RaWriteEn, Rdest, writeData; fwd_* bypass ports when WB_FORWARD_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int REGBITS = 5,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic               ex_reg_write,
    input  logic [1:0]         ex_wb_sel,
    input  logic [1:0]         ex_ld_size,
    input  logic               ex_ld_signed,
    input  logic [REGBITS-1:0] ex_rdest,
    input  logic [WIDTH-1:0]   ex_alu_result,
    input  logic [WIDTH-1:0]   ex_link_addr,
    input  logic               mem_rvalid,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic               regWriteEn,
    output logic               RaWriteEn,
    output logic [REGBITS-1:0] Rdest,
    output logic [WIDTH-1:0]   writeData
`ifdef WB_FORWARD_EN
    ,
    output logic               fwd_valid,
    output logic [REGBITS-1:0] fwd_rdest,
    output logic [WIDTH-1:0]   fwd_data
`endif
);

    wb_state_e          state, state_nxt;
    logic [REGBITS-1:0] cap_rdest;
    logic [1:0]         cap_size;
    logic               cap_signed;
    logic [1:0]         cap_addr;
    logic               we_nxt, ra_nxt;
    logic [REGBITS-1:0] rdest_nxt;
    logic [WIDTH-1:0]   data_nxt;
    logic [WIDTH-1:0]   ld_data;
    logic               accept, is_mem, is_link;

    assign ex_ready = (state != S_WAIT_MEM);
    assign accept   = ex_valid & ex_ready;
    assign is_mem   = (ex_wb_sel == WB_MEM);
    assign is_link  = (ex_wb_sel == WB_LINK);

    load_extend #(.WIDTH(WIDTH)) u_ext (
        .mem_rdata (mem_rdata),
        .addr      (cap_addr),
        .size      (cap_size),
        .sgn       (cap_signed),
        .result    (ld_data)
    );

    // Data/Rdest default to their current value so they hold
    // whenever no strobe is issued (including suppressed R0 writes).
    always_comb begin
        state_nxt = state;
        we_nxt    = 1'b0;
        ra_nxt    = 1'b0;
        rdest_nxt = Rdest;
        data_nxt  = writeData;
        case (state)
            S_WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_nxt = S_WRITE;
                    if (cap_rdest != '0) begin
                        we_nxt    = 1'b1;
                        rdest_nxt = cap_rdest;
                        data_nxt  = ld_data;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                if (accept && ex_reg_write) begin
                    unique case (1'b1)
                        is_mem: begin
                            state_nxt = S_WAIT_MEM;
                        end
                        is_link: begin
                            state_nxt = S_WRITE;
                            ra_nxt    = 1'b1;
                            rdest_nxt = REGBITS'(RA_REG);
                            data_nxt  = ex_link_addr;
                        end
                        default: begin
                            state_nxt = S_WRITE;
                            if (ex_rdest != '0) begin
                                we_nxt    = 1'b1;
                                rdest_nxt = ex_rdest;
                                data_nxt  = ex_alu_result;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_rdest  <= '0;
            cap_size   <= '0;
            cap_signed <= 1'b0;
            cap_addr   <= '0;
        end else if (accept && ex_reg_write && is_mem) begin
            cap_rdest  <= ex_rdest;
            cap_size   <= ex_ld_size;
            cap_signed <= ex_ld_signed;
            cap_addr   <= ex_alu_result[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            regWriteEn <= 1'b0;
            RaWriteEn  <= 1'b0;
            Rdest      <= '0;
            writeData  <= '0;
        end else begin
            state      <= state_nxt;
            regWriteEn <= we_nxt;
            RaWriteEn  <= ra_nxt;
            Rdest      <= rdest_nxt;
            writeData  <= data_nxt;
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_valid = (state == S_WRITE) & (regWriteEn | RaWriteEn);
    assign fwd_rdest = Rdest;
    assign fwd_data  = writeData;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: vector table, directed load/reset sequences and a
// randomized run against a transaction-level reference model.
module tb_wb_stage;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_ready, ex_reg_write, ex_ld_signed;
    logic [1:0]  ex_wb_sel, ex_ld_size;
    logic [4:0]  ex_rdest;
    logic [31:0] ex_alu_result, ex_link_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        regWriteEn, RaWriteEn;
    logic [4:0]  Rdest;
    logic [31:0] writeData;
`ifdef WB_FORWARD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rdest;
    logic [31:0] fwd_data;
`endif

    always #5 clk = ~clk;

    wb_stage #(.REGBITS(5), .WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_reg_write  (ex_reg_write),
        .ex_wb_sel     (ex_wb_sel),
        .ex_ld_size    (ex_ld_size),
        .ex_ld_signed  (ex_ld_signed),
        .ex_rdest      (ex_rdest),
        .ex_alu_result (ex_alu_result),
        .ex_link_addr  (ex_link_addr),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .regWriteEn    (regWriteEn),
        .RaWriteEn     (RaWriteEn),
        .Rdest         (Rdest),
        .writeData     (writeData)
`ifdef WB_FORWARD_EN
        ,
        .fwd_valid     (fwd_valid),
        .fwd_rdest     (fwd_rdest),
        .fwd_data      (fwd_data)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_fwd(input string name, input logic v,
                           input logic [4:0] rd, input logic [31:0] d);
`ifdef WB_FORWARD_EN
        chk(name, fwd_valid, v);
        if (v) chk({name, "_data"}, {fwd_rdest, fwd_data}, {rd, d});
`else
        if (v === 1'bx) $display("unexpected x on %s %h %h", name, rd, d);
`endif
    endtask

    task automatic idle_in();
        ex_valid      = 1'b0;
        ex_reg_write  = 1'b0;
        ex_wb_sel     = 2'b00;
        ex_ld_size    = 2'b00;
        ex_ld_signed  = 1'b0;
        ex_rdest      = 5'd0;
        ex_alu_result = 32'h0;
        ex_link_addr  = 32'h0;
        mem_rvalid    = 1'b0;
    endtask

    task automatic issue(input logic rw, input logic [1:0] sel,
                         input logic [1:0] sz, input logic sg,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] link);
        ex_valid      = 1'b1;
        ex_reg_write  = rw;
        ex_wb_sel     = sel;
        ex_ld_size    = sz;
        ex_ld_signed  = sg;
        ex_rdest      = rd;
        ex_alu_result = alu;
        ex_link_addr  = link;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    logic        m_busy, m_we, m_ra, m_sg;
    logic [4:0]  m_rdest, m_rd;
    logic [1:0]  m_sz, m_a;
    logic [31:0] m_data;

    function automatic logic [31:0] ext(input logic [31:0] d,
                                        input logic [1:0] sz,
                                        input logic s,
                                        input logic [1:0] a);
        logic [31:0] v;
        int sh;
        if (sz == 2'b10) begin
            sh = 8 * int'(a);
            v = (d >> sh) & 32'hFF;
            if (s && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            sh = a[1] ? 16 : 0;
            v = (d >> sh) & 32'hFFFF;
            if (s && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_we = 0; m_ra = 0;
        m_rdest = 0; m_data = 0;
        m_rd = 0; m_sz = 0; m_sg = 0; m_a = 0;
    endtask

    task automatic model_step();
        m_we = 0;
        m_ra = 0;
        if (!m_busy) begin
            if (ex_valid && ex_reg_write) begin
                if (ex_wb_sel == 2'b01) begin
                    m_busy = 1;
                    m_rd = ex_rdest;
                    m_sz = ex_ld_size;
                    m_sg = ex_ld_signed;
                    m_a  = ex_alu_result[1:0];
                end else if (ex_wb_sel == 2'b10) begin
                    m_ra = 1;
                    m_rdest = 5'd31;
                    m_data = ex_link_addr;
                end else if (ex_rdest != 0) begin
                    m_we = 1;
                    m_rdest = ex_rdest;
                    m_data = ex_alu_result;
                end
            end
        end else if (mem_rvalid) begin
            m_busy = 0;
            if (m_rd != 0) begin
                m_we = 1;
                m_rdest = m_rd;
                m_data = ext(mem_rdata, m_sz, m_sg, m_a);
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rw;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] link;
        logic        we;
        logic        ra;
        logic [4:0]  erd;
        logic [31:0] edata;
    } vec_t;

    vec_t vt[6];

    task automatic mem_seq(input logic sg, input logic [31:0] exp,
                           input string name);
        issue(1'b1, 2'b01, 2'b10, sg, 5'd12, 32'h0000_1002, 32'h0);
        tick();
        idle_in();
        mem_rdata = 32'h0080_0000;
        for (int i = 0; i < 3; i++) begin
            chk({name, "_ready_wait"}, ex_ready, 1'b0);
            chk({name, "_nostrobe_wait"}, {regWriteEn, RaWriteEn}, 2'b00);
            if (i < 2) tick();
        end
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk({name, "_out"}, {regWriteEn, RaWriteEn, Rdest, writeData},
            {1'b1, 1'b0, 5'd12, exp});
        chk_fwd({name, "_fwd"}, 1'b1, 5'd12, exp);
        chk({name, "_ready_after"}, ex_ready, 1'b1);
        tick();
        chk({name, "_pulse"}, {regWriteEn, RaWriteEn}, 2'b00);
    endtask

    initial begin
        vt[0] = '{1'b1, 2'b00, 5'd5, 32'h1234, 32'h0,
                  1'b1, 1'b0, 5'd5, 32'h1234};
        vt[1] = '{1'b1, 2'b10, 5'd7, 32'h999, 32'h40,
                  1'b0, 1'b1, 5'd31, 32'h40};
        vt[2] = '{1'b1, 2'b00, 5'd0, 32'hABC, 32'h0,
                  1'b0, 1'b0, 5'd31, 32'h40};
        vt[3] = '{1'b0, 2'b00, 5'd4, 32'h77, 32'h0,
                  1'b0, 1'b0, 5'd31, 32'h40};
        vt[4] = '{1'b1, 2'b11, 5'd9, 32'hDEAD_BEEF, 32'h55,
                  1'b1, 1'b0, 5'd9, 32'hDEAD_BEEF};
        vt[5] = '{1'b0, 2'b10, 5'd3, 32'h1, 32'h88,
                  1'b0, 1'b0, 5'd9, 32'hDEAD_BEEF};

        idle_in();
        mem_rdata = 32'h0;
        reset = 1'b1;
        tick();
        tick();
        chk("reset_out", {regWriteEn, RaWriteEn, Rdest, writeData}, 64'h0);
        chk("reset_ready", ex_ready, 1'b1);
        chk_fwd("reset_fwd", 1'b0, 5'd0, 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            issue(vt[i].rw, vt[i].sel, 2'b00, 1'b0, vt[i].rd,
                  vt[i].alu, vt[i].link);
            chk("vec_ready", ex_ready, 1'b1);
            tick();
            chk("vec_out", {regWriteEn, RaWriteEn, Rdest, writeData},
                {vt[i].we, vt[i].ra, vt[i].erd, vt[i].edata});
            chk_fwd("vec_fwd", vt[i].we | vt[i].ra, vt[i].erd, vt[i].edata);
            idle_in();
            tick();
            chk("vec_pulse", {regWriteEn, RaWriteEn, Rdest, writeData},
                {1'b0, 1'b0, vt[i].erd, vt[i].edata});
        end

        mem_seq(1'b1, 32'hFFFF_FF80, "ld_byte_s");
        mem_seq(1'b0, 32'h0000_0080, "ld_byte_u");

        for (int k = 0; k < 3; k++) begin
            issue(1'b1, 2'b00, 2'b00, 1'b0, 5'(k + 1),
                  32'h100 + 32'(k), 32'h0);
            chk("b2b_ready", ex_ready, 1'b1);
            tick();
            chk("b2b_out", {regWriteEn, RaWriteEn, Rdest, writeData},
                {1'b1, 1'b0, 5'(k + 1), 32'h100 + 32'(k)});
        end
        idle_in();
        tick();
        chk("b2b_end", {regWriteEn, RaWriteEn}, 2'b00);

        issue(1'b1, 2'b01, 2'b00, 1'b0, 5'd3, 32'h0, 32'h0);
        tick();
        idle_in();
        chk("rstwait_ready0", ex_ready, 1'b0);
        reset = 1'b1;
        #1;
        chk("rstwait_ready_in_reset", ex_ready, 1'b1);
        tick();
        reset = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        chk("rstwait_nostrobe", {regWriteEn, RaWriteEn}, 2'b00);
        chk("rstwait_ready", ex_ready, 1'b1);
        tick();
        chk("rstwait_nostrobe2", {regWriteEn, RaWriteEn}, 2'b00);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            ex_valid      = ($urandom_range(0, 9) < 7);
            ex_reg_write  = ($urandom_range(0, 9) < 8);
            ex_wb_sel     = 2'($urandom_range(0, 3));
            ex_ld_size    = 2'($urandom_range(0, 2));
            ex_ld_signed  = 1'($urandom_range(0, 1));
            ex_rdest      = ($urandom_range(0, 7) == 0) ? 5'd0
                            : 5'($urandom_range(1, 31));
            ex_alu_result = $urandom;
            ex_link_addr  = $urandom;
            mem_rvalid    = ($urandom_range(0, 9) < 4);
            mem_rdata     = $urandom;
            chk("rnd_ready", ex_ready, !m_busy);
            model_step();
            tick();
            chk("rnd_out", {regWriteEn, RaWriteEn, Rdest, writeData},
                {m_we, m_ra, m_rdest, m_data});
            chk_fwd("rnd_fwd", m_we | m_ra, m_rdest, m_data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
